// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the multi-context CGRA processing element: opcodes,
// source-select codes, width helpers and the default packed instruction layout.
package pe_ctx_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_MUL   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_SHL   = 5'd7;
    localparam logic [4:0] OP_SHR   = 5'd8;
    localparam logic [4:0] OP_SRA   = 5'd9;
    localparam logic [4:0] OP_LT    = 5'd10;
    localparam logic [4:0] OP_EQ    = 5'd11;
    localparam logic [4:0] OP_PASSA = 5'd12;
    localparam logic [4:0] OP_ACC   = 5'd13;

    localparam int unsigned SRC_N   = 0;
    localparam int unsigned SRC_S   = 1;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned SRC_E   = 3;
    localparam int unsigned SRC_RES = 4;
    localparam int unsigned SRC_R0  = 5;

    function automatic int unsigned sel_w(input int unsigned nreg);
        return $clog2(5 + nreg);
    endfunction

    function automatic int unsigned ri_w(input int unsigned nreg);
        return $clog2(nreg);
    endfunction

    function automatic int unsigned ca_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned inst_w(input int unsigned nreg);
        return 5 + 7 * sel_w(nreg) + 1 + ri_w(nreg);
    endfunction

    localparam int unsigned DEF_DW   = 32;
    localparam int unsigned DEF_NREG = 4;
    localparam int unsigned DEF_SELW = sel_w(DEF_NREG);
    localparam int unsigned DEF_RIW  = ri_w(DEF_NREG);

    // Instruction word at the default NREG; field order is MSB to LSB.
    typedef struct packed {
        logic [4:0]          opcode;
        logic [DEF_SELW-1:0] sel_a;
        logic [DEF_SELW-1:0] sel_b;
        logic [DEF_SELW-1:0] sel_n;
        logic [DEF_SELW-1:0] sel_s;
        logic [DEF_SELW-1:0] sel_w;
        logic [DEF_SELW-1:0] sel_e;
        logic                rf_we;
        logic [DEF_RIW-1:0]  rf_idx;
        logic [DEF_SELW-1:0] rf_src;
    } inst_t;

endpackage

// File: rtl/pe_ctx_fu.sv
// Combinational ALU of the PE: computes the next result register value.
// PE_CTX_ACC_EN enables the single-cycle MAC on opcode 13.
module pe_ctx_fu
    import pe_ctx_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] res,
    input  logic [4:0]    opcode,
    output logic [DW-1:0] next_res
);

    localparam int unsigned SHW = $clog2(DW);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        next_res = res;
        case (opcode)
            OP_ADD:   next_res = a + b;
            OP_SUB:   next_res = a - b;
            OP_MUL:   next_res = a * b;
            OP_AND:   next_res = a & b;
            OP_OR:    next_res = a | b;
            OP_XOR:   next_res = a ^ b;
            OP_SHL:   next_res = a << shamt;
            OP_SHR:   next_res = a >> shamt;
            OP_SRA:   next_res = DW'($signed(a) >>> shamt);
            OP_LT:    next_res = DW'($signed(a) < $signed(b));
            OP_EQ:    next_res = DW'(a == b);
            OP_PASSA: next_res = a;
`ifdef PE_CTX_ACC_EN
            OP_ACC:   next_res = res + a * b;
`endif
            default:  next_res = res;
        endcase
    end

endmodule

// File: rtl/pe_ctx.sv
// Multi-context CGRA processing element: context memory stepped modulo ii,
// shared result register and register file. PE_CTX_ACC_EN enables opcode 13 MAC.
module pe_ctx
    import pe_ctx_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned NREG      = 4,
    parameter int unsigned CTX_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_we,
    input  logic [ca_w(CTX_DEPTH)-1:0]      cfg_addr,
    input  logic [inst_w(NREG)-1:0]         cfg_data,
    input  logic                            start,
    input  logic                            stop,
    input  logic [ca_w(CTX_DEPTH):0]        ii,
    input  logic [DW-1:0]                   din_N,
    input  logic [DW-1:0]                   din_S,
    input  logic [DW-1:0]                   din_W,
    input  logic [DW-1:0]                   din_E,
    output logic [DW-1:0]                   dout_N,
    output logic [DW-1:0]                   dout_S,
    output logic [DW-1:0]                   dout_W,
    output logic [DW-1:0]                   dout_E,
    output logic                            busy,
    output logic [ca_w(CTX_DEPTH)-1:0]      pc
);

    localparam int unsigned SELW   = sel_w(NREG);
    localparam int unsigned RIW    = ri_w(NREG);
    localparam int unsigned CAW    = ca_w(CTX_DEPTH);
    localparam int unsigned INST_W = inst_w(NREG);
    localparam int unsigned NSRC   = 1 << SELW;

    typedef struct packed {
        logic [4:0]      opcode;
        logic [SELW-1:0] sel_a;
        logic [SELW-1:0] sel_b;
        logic [SELW-1:0] sel_n;
        logic [SELW-1:0] sel_s;
        logic [SELW-1:0] sel_w;
        logic [SELW-1:0] sel_e;
        logic            rf_we;
        logic [RIW-1:0]  rf_idx;
        logic [SELW-1:0] rf_src;
    } ctx_inst_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CAW-1:0]  pc_q, pc_d;
    logic [CAW:0]    ii_q, ii_d;
    logic [DW-1:0]   res_q, res_d;
    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   rf_d [NREG];
    logic            busy_q, busy_d;

    logic [INST_W-1:0] ctx_mem_q [CTX_DEPTH];
    logic              ctx_we_c;
    ctx_inst_t         inst_c;
    logic              running_c;
    logic [DW-1:0]     src_c [NSRC];
    logic [DW-1:0]     fu_res_c;

    assign running_c = (state_q == ST_RUN);
    assign inst_c    = ctx_inst_t'(ctx_mem_q[pc_q]);

    // FSM next state and context counter; stop wins over pc increment.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ii_d     = ii_q;
        ctx_we_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ctx_we_c = cfg_we;
                if (start && (ii != '0) && (ii <= (CAW+1)'(CTX_DEPTH))) begin
                    state_d = ST_RUN;
                    ii_d    = ii;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end else if ((CAW+1)'(pc_q) + (CAW+1)'(1) >= ii_q) begin
                    pc_d = '0;
                end else begin
                    pc_d = pc_q + CAW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // Source bus: neighbours, result, register file; unused codes read 0.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_c[i] = '0;
        end
        src_c[SRC_N]   = din_N;
        src_c[SRC_S]   = din_S;
        src_c[SRC_W]   = din_W;
        src_c[SRC_E]   = din_E;
        src_c[SRC_RES] = res_q;
        for (int i = 0; i < NREG; i++) begin
            src_c[SRC_R0 + i] = rf_q[i];
        end
    end

    pe_ctx_fu #(
        .DW (DW)
    ) u_fu (
        .a        (src_c[inst_c.sel_a]),
        .b        (src_c[inst_c.sel_b]),
        .res      (res_q),
        .opcode   (inst_c.opcode),
        .next_res (fu_res_c)
    );

    // RF write sees the pre-update result through the source bus.
    always_comb begin
        res_d = res_q;
        rf_d  = rf_q;
        if (running_c) begin
            res_d = fu_res_c;
            if (inst_c.rf_we) begin
                rf_d[inst_c.rf_idx] = src_c[inst_c.rf_src];
            end
        end
    end

    assign dout_N = running_c ? src_c[inst_c.sel_n] : '0;
    assign dout_S = running_c ? src_c[inst_c.sel_s] : '0;
    assign dout_W = running_c ? src_c[inst_c.sel_w] : '0;
    assign dout_E = running_c ? src_c[inst_c.sel_e] : '0;
    assign busy   = busy_q;
    assign pc     = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ii_q    <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ii_q    <= ii_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Context memory survives reset.
    always_ff @(posedge clk) begin
        if (ctx_we_c) begin
            ctx_mem_q[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_pe_ctx.sv
// Bench for pe_ctx: directed programs, a per-cycle reference model of the PE,
// and literal expectations at the key points of each scenario.
module tb_pe_ctx;
    import pe_ctx_pkg::*;

    localparam int unsigned SW = DEF_SELW;
    localparam int unsigned RW = DEF_RIW;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [35:0] cfg_data;
    logic        start;
    logic        stop;
    logic [3:0]  ii;
    logic [31:0] din_N, din_S, din_W, din_E;
    logic [31:0] dout_N, dout_S, dout_W, dout_E;
    logic        busy;
    logic [2:0]  pc;

    int checks = 0;
    int fails  = 0;

    pe_ctx dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop), .ii(ii),
        .din_N(din_N), .din_S(din_S), .din_W(din_W), .din_E(din_E),
        .dout_N(dout_N), .dout_S(dout_S), .dout_W(dout_W), .dout_E(dout_E),
        .busy(busy), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    inst_t       m_ctx [8];
    bit          m_valid = 1'b0;
    bit          m_run;
    int unsigned m_pc, m_ii;
    logic [31:0] m_res;
    logic [31:0] m_rf [4];
    inst_t       m_t;
    logic [31:0] m_nr;
    inst_t       c_t;

    function automatic logic [31:0] m_src(input int unsigned sel);
        case (sel)
            0: return din_N;
            1: return din_S;
            2: return din_W;
            3: return din_E;
            4: return m_res;
            5, 6, 7, 8: return m_rf[sel - 5];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] r);
        int unsigned sh;
        sh = 32'(b[4:0]);
        case (op)
            1:  return a + b;
            2:  return a - b;
            3:  return a * b;
            4:  return a & b;
            5:  return a | b;
            6:  return a ^ b;
            7:  return a << sh;
            8:  return a >> sh;
            9:  return 32'($signed(a) >>> sh);
            10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            11: return (a == b) ? 32'd1 : 32'd0;
            12: return a;
`ifdef PE_CTX_ACC_EN
            13: return r + a * b;
`endif
            default: return r;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_pc    = 0;
            m_ii    = 1;
            m_res   = 32'd0;
            for (int i = 0; i < 4; i++) m_rf[i] = 32'd0;
        end else if (m_valid && !m_run) begin
            if (cfg_we) m_ctx[cfg_addr] = inst_t'(cfg_data);
            if (start && ii >= 4'd1 && ii <= 4'd8) begin
                m_run = 1'b1;
                m_ii  = 32'(ii);
                m_pc  = 0;
            end
        end else if (m_valid) begin
            m_t  = m_ctx[m_pc];
            m_nr = m_alu(m_t.opcode, m_src(32'(m_t.sel_a)), m_src(32'(m_t.sel_b)), m_res);
            if (m_t.rf_we) m_rf[m_t.rf_idx] = m_src(32'(m_t.rf_src));
            m_res = m_nr;
            if (stop) begin
                m_run = 1'b0;
                m_pc  = 0;
            end else begin
                m_pc = (m_pc + 1) % m_ii;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), m_run ? 32'd1 : 32'd0);
            chk("pc", 32'(pc), m_pc);
            if (m_run) begin
                c_t = m_ctx[m_pc];
                chk("dout_N", dout_N, m_src(32'(c_t.sel_n)));
                chk("dout_S", dout_S, m_src(32'(c_t.sel_s)));
                chk("dout_W", dout_W, m_src(32'(c_t.sel_w)));
                chk("dout_E", dout_E, m_src(32'(c_t.sel_e)));
            end else begin
                chk("dout_N_idle", dout_N, 32'd0);
                chk("dout_S_idle", dout_S, 32'd0);
                chk("dout_W_idle", dout_W, 32'd0);
                chk("dout_E_idle", dout_E, 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic inst_t mk(input logic [4:0] op, input int unsigned a, input int unsigned b,
                                 input int unsigned n, input int unsigned s, input int unsigned w,
                                 input int unsigned e, input logic we, input int unsigned idx,
                                 input int unsigned src);
        inst_t t;
        t.opcode = op;
        t.sel_a  = SW'(a);
        t.sel_b  = SW'(b);
        t.sel_n  = SW'(n);
        t.sel_s  = SW'(s);
        t.sel_w  = SW'(w);
        t.sel_e  = SW'(e);
        t.rf_we  = we;
        t.rf_idx = RW'(idx);
        t.rf_src = SW'(src);
        return t;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unsigned a, input inst_t t);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = t;
        cyc();
        cfg_we   = 1'b0;
    endtask

    task automatic go(input int unsigned n);
        start = 1'b1;
        ii    = 4'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    localparam int unsigned R2 = SRC_R0 + 2;
    int unsigned pc_seq [6] = '{0, 1, 2, 3, 0, 1};
    logic [4:0]  ops [8] = '{OP_SUB, OP_MUL, OP_OR, OP_XOR, OP_SHL, OP_SRA, OP_LT, OP_EQ};
    logic [31:0] tn [5] = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h8000_0001, 32'h1234_5678, 32'h0000_0005};
    logic [31:0] ts [5] = '{32'h0000_0003, 32'h0000_0021, 32'h0000_001F, 32'h1234_5678, 32'hFFFF_FFFF};

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; ii = '0;
        din_N = 32'h11; din_S = 32'h22; din_W = 32'h33; din_E = 32'h44;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_dout_N", dout_N, 32'd0);
        chk("rst_dout_E", dout_E, 32'd0);

        // pc sequence with ii=4
        for (int k = 0; k < 4; k++) wr(k, mk(OP_NOP, SRC_N, SRC_N, SRC_N, SRC_S, SRC_W, SRC_E, 1'b0, 0, 0));
        go(4);
        chk("run_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("pc_seq", 32'(pc), pc_seq[k]);
            cyc();
        end
        halt();
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_pc", 32'(pc), 32'd0);

        // ADD routed to dout_E, ii=1
        do_reset();
        wr(0, mk(OP_ADD, SRC_N, SRC_W, SRC_N, SRC_S, SRC_W, SRC_RES, 1'b0, 0, 0));
        din_N = 32'd5; din_W = 32'd7;
        go(1);
        chk("add_first", dout_E, 32'd0);
        cyc();
        chk("add_second", dout_E, 32'd12);
        halt();

        // PASSA into R2, read back in ctx1
        do_reset();
        wr(0, mk(OP_PASSA, SRC_N, SRC_N, SRC_N, SRC_S, SRC_W, SRC_E, 1'b1, 2, SRC_N));
        wr(1, mk(OP_NOP, SRC_N, SRC_N, SRC_N, R2, SRC_W, SRC_RES, 1'b1, 1, SRC_RES));
        din_N = 32'h0000_DEAD;
        go(2);
        chk("rf_pc0", 32'(pc), 32'd0);
        cyc();
        chk("rf_route_S", dout_S, 32'h0000_DEAD);
        chk("rf_res_E", dout_E, 32'h0000_DEAD);
        din_N = 32'h0000_1234; din_W = 32'h0000_0077;
        cyc();
        // Context write while running is dropped
        cfg_we = 1'b1; cfg_addr = 3'd0;
        cfg_data = mk(OP_XOR, SRC_W, SRC_W, SRC_W, SRC_W, SRC_W, SRC_W, 1'b0, 0, 0);
        cyc();
        cfg_we = 1'b0;
        cyc();
        chk("cfg_in_run", dout_N, 32'h0000_1234);
        halt();
        go(0);
        chk("ii0_ignored", 32'(busy), 32'd0);
        go(9);
        chk("ii9_ignored", 32'(busy), 32'd0);

        // ACC with write+start in the same cycle
        do_reset();
        din_N = 32'd3; din_W = 32'd4;
        cfg_we = 1'b1; cfg_addr = 3'd0;
        cfg_data = mk(OP_ACC, SRC_N, SRC_W, SRC_N, SRC_S, SRC_W, SRC_RES, 1'b0, 0, 0);
        start = 1'b1; ii = 4'd1;
        cyc();
        cfg_we = 1'b0; start = 1'b0;
        chk("acc_0", dout_E, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
`ifdef PE_CTX_ACC_EN
            chk("acc_k", dout_E, 32'(12 * k));
`else
            chk("acc_k", dout_E, 32'd0);
`endif
        end
        halt();

        // Reset mid-run keeps context memory
        do_reset();
        wr(0, mk(OP_PASSA, SRC_N, SRC_N, SRC_N, SRC_S, SRC_W, SRC_RES, 1'b0, 0, 0));
        for (int k = 1; k < 4; k++) wr(k, mk(OP_NOP, SRC_N, SRC_N, SRC_N, SRC_S, SRC_W, SRC_RES, 1'b0, 0, 0));
        din_N = 32'd99;
        go(4);
        cyc(); cyc();
        chk("mid_pc2", 32'(pc), 32'd2);
        chk("mid_res99", dout_E, 32'd99);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_dout", dout_E, 32'd0);
        din_N = 32'd42;
        go(4);
        chk("restart_res", dout_E, 32'd0);
        cyc();
        chk("restart_passa", dout_E, 32'd42);
        halt();

        // Mixed ALU program over all eight contexts, model-checked
        do_reset();
        for (int k = 0; k < 8; k++)
            wr(k, mk(ops[k], SRC_N, SRC_S, SRC_RES, SRC_R0 + (k % 4), SRC_W, SRC_RES,
                     1'b1, k % 4, (k % 2 == 0) ? SRC_RES : SRC_E));
        din_W = 32'h5A5A_5A5A; din_E = 32'h0F0F_0F0F;
        go(8);
        for (int c = 0; c < 20; c++) begin
            din_N = tn[c % 5];
            din_S = ts[(c + 2) % 5];
            cyc();
        end
        halt();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
